uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Second-generation UART transmitter with a parametrised character width, runtime-selectable parity and stop-bit count, and a small input FIFO that decouples the producer from line timing. It serialises queued characters onto the TX pin back-to-back with no idle gaps. It sits between the case-converter datapath and the board TX pin, in place of the single-character transmitter.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 9600, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), must be >= 2
DATA_BITS, 8, character width, legal range 5..9
FIFO_DEPTH, 4, input FIFO entries, power of two, >= 2

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst_n  input  1  synchronous active-low reset
i_data  input  DATA_BITS  character to queue
i_valid  input  1  push request; accepted only when o_ready=1
o_ready  output  1  FIFO not full
i_parity_mode  input  2  00 none, 01 odd, 10 even, 11 none
i_two_stop  input  1  1 = two stop bits, 0 = one
i_break  input  1  break request (active only with UART_TX_BREAK_EN)
o_out  output  1  serial line, idle high
o_busy  output  1  frame or break in progress
o_fifo_level  output  $clog2(FIFO_DEPTH)+1  entries currently queued

Behaviour:
- Interface decided: one clock i_clk; reset i_rst_n is synchronous, active-low.
- Reset, and any cycle with i_rst_n=0: o_out=1, o_busy=0, FIFO empty (o_fifo_level=0, o_ready=1), FSM in IDLE. A reset mid-frame aborts the frame; o_out is high on the next edge.
- FIFO push: i_valid & o_ready at an edge writes i_data. Push while full is dropped silently. o_ready is purely !full, so a push in a full cycle is dropped even if a pop occurs in the same cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: level is unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP, plus BREAK and MARK when UART_TX_BREAK_EN is defined.
- IDLE: o_out=1. If the FIFO is non-empty, pop the head and latch the character, i_parity_mode and i_two_stop. The next cycle enters START with o_out=0.
  - Latency: push at cycle t, start bit visible at t+2.
- Each bit is exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded to CLKS_PER_BIT-1 at every bit boundary.
- DATA: LSB first, DATA_BITS bits.
- PARITY: entered only if latched mode is 01 or 10.
  - Odd parity: bit = ~^data.
  - Even parity: bit = ^data.
  - Parity is computed over DATA_BITS bits only.
- STOP: o_out=1 for 1 or 2 bit times.
  - On the last cycle of the final stop bit: if the FIFO is non-empty, pop and go directly to START (no gap); otherwise go to IDLE.
- Frame length = (1 + DATA_BITS + parity?1:0 + stop) * CLKS_PER_BIT cycles.
- Config inputs changed mid-frame affect only the next frame.
- o_busy=1 in every state except IDLE.
- Illegal state encoding: recover to IDLE with o_out=1 on the next edge.

Optional Feature:
UART_TX_BREAK_EN
- Defined:
  - i_break is sampled only in IDLE or at a frame boundary, and has priority over a pending FIFO pop.
  - BREAK: o_out=0 from the next cycle for as long as i_break stays high, with a minimum of one full frame length.
  - MARK: on release, o_out=1 for one bit time, then the FSM returns to IDLE/pop.
  - FIFO contents are preserved across a break.
- Undefined: i_break is ignored; the BREAK and MARK states and their logic are not generated.

Test Plan:
All scenarios use CLK_FREQ=1000000, BAUD=100000 (CLKS_PER_BIT=10), DATA_BITS=8, FIFO_DEPTH=4.
1. 8N1, push 0x55 at cycle t -> o_out=0 from t+2 for 10 cycles, then bits 1,0,1,0,1,0,1,0 at 10 cycles each, then stop high; o_busy high for exactly 100 cycles.
2. Even parity, push 0x07 -> parity bit 1. Odd parity, push 0x07 -> parity bit 0. Odd parity with i_two_stop=1 -> frame is 120 cycles.
3. Push 6 characters on consecutive cycles from idle -> first five accepted; o_ready=0 and o_fifo_level=4 on the 6th push, which is dropped; five frames transmitted contiguously over 500 cycles with no high gap between stop and start bits.
4. Assert i_rst_n=0 for 1 cycle during data bit 3 with 2 characters queued -> next edge o_out=1, o_busy=0, o_fifo_level=0; a subsequent push of 0xA3 yields a clean frame.
5. Toggle i_parity_mode 00->10 mid-frame -> current frame has no parity bit; the next queued frame carries the parity bit.
6. (UART_TX_BREAK_EN) i_break high for 150 cycles while idle with 1 character queued -> o_out low for 150 cycles, then high for 10 cycles, then the queued frame starts. Without the macro, o_out is unaffected.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: DATA_BITS characters, runtime parity (none/odd/even) and 1/2 stop bits.
// Define UART_TX_BREAK_EN to add line-break generation (BREAK/MARK states driven by i_break).
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [DATA_BITS-1:0]        i_data,
   input  logic                        i_valid,
   output logic                        o_ready,
   input  logic [1:0]                  i_parity_mode,
   input  logic                        i_two_stop,
   input  logic                        i_break,
   output logic                        o_out,
   output logic                        o_busy,
   output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);
   // state   | meaning
   // IDLE    | line high, pop when FIFO non-empty
   // START   | start bit (low)
   // DATA    | DATA_BITS data bits, LSB first
   // PARITY  | parity bit, only for odd/even modes
   // STOP    | one or two stop bits (high); frame boundary on the last cycle
   // BREAK   | line held low, at least one frame length
   // MARK    | one bit time high after a break
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int BIT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
      , S_BREAK = 3'd5,
      S_MARK    = 3'd6
`endif
   } state_t;

   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
   logic [LVL_W-1:0]     r_level;
   logic                 w_full, w_empty, w_push, w_pop;
   logic [DATA_BITS-1:0] w_head;

   state_t               r_state, w_state_nxt;
   logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
   logic [BIT_W-1:0]     r_bit_idx, w_bit_idx_nxt;
   logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
   logic                 r_par_en, w_par_en_nxt;
   logic                 r_par_bit, w_par_bit_nxt;
   logic                 r_two_stop, w_two_stop_nxt;
   logic                 r_stop_idx, w_stop_idx_nxt;
   logic                 w_tick, w_boundary, w_out;

`ifdef UART_TX_BREAK_EN
   localparam int BRK_W = $clog2(13 * CLKS_PER_BIT);
   localparam logic [BRK_W-1:0] BRK_BASE = BRK_W'((2 + DATA_BITS) * CLKS_PER_BIT - 1);
   localparam logic [BRK_W-1:0] BRK_BIT  = BRK_W'(CLKS_PER_BIT);
   logic [BRK_W-1:0] r_brk_cnt, w_brk_cnt_nxt;
`else
   logic w_unused;
   assign w_unused = i_break;
`endif

   assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
   assign w_empty = (r_level == '0);
   assign w_push  = i_valid & ~w_full;
   assign w_head  = r_mem[r_rd_ptr];
   assign w_tick  = (r_cnt == '0);

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_par_en   <= 1'b0;
         r_par_bit  <= 1'b0;
         r_two_stop <= 1'b0;
         r_stop_idx <= 1'b0;
`ifdef UART_TX_BREAK_EN
         r_brk_cnt  <= '0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_bit_idx  <= w_bit_idx_nxt;
         r_shift    <= w_shift_nxt;
         r_par_en   <= w_par_en_nxt;
         r_par_bit  <= w_par_bit_nxt;
         r_two_stop <= w_two_stop_nxt;
         r_stop_idx <= w_stop_idx_nxt;
`ifdef UART_TX_BREAK_EN
         r_brk_cnt  <= w_brk_cnt_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_bit_idx_nxt  = r_bit_idx;
      w_shift_nxt    = r_shift;
      w_par_en_nxt   = r_par_en;
      w_par_bit_nxt  = r_par_bit;
      w_two_stop_nxt = r_two_stop;
      w_stop_idx_nxt = r_stop_idx;
      w_pop          = 1'b0;
      w_out          = 1'b1;
      w_boundary     = 1'b0;
`ifdef UART_TX_BREAK_EN
      w_brk_cnt_nxt  = r_brk_cnt;
`endif
      case (r_state)
         S_IDLE: w_boundary = 1'b1;
         S_START: begin
            w_out = 1'b0;
            if (w_tick) begin
               w_state_nxt   = S_DATA;
               w_cnt_nxt     = CNT_LAST;
               w_bit_idx_nxt = '0;
            end else w_cnt_nxt = r_cnt - 1'b1;
         end
         S_DATA: begin
            w_out = r_shift[0];
            if (w_tick) begin
               w_cnt_nxt     = CNT_LAST;
               w_shift_nxt   = r_shift >> 1;
               w_bit_idx_nxt = r_bit_idx + 1'b1;
               if (r_bit_idx == BIT_LAST) begin
                  w_state_nxt    = r_par_en ? S_PARITY : S_STOP;
                  w_stop_idx_nxt = 1'b0;
               end
            end else w_cnt_nxt = r_cnt - 1'b1;
         end
         S_PARITY: begin
            w_out = r_par_bit;
            if (w_tick) begin
               w_state_nxt    = S_STOP;
               w_cnt_nxt      = CNT_LAST;
               w_stop_idx_nxt = 1'b0;
            end else w_cnt_nxt = r_cnt - 1'b1;
         end
         S_STOP: begin
            if (w_tick) begin
               if (r_two_stop && !r_stop_idx) begin
                  w_stop_idx_nxt = 1'b1;
                  w_cnt_nxt      = CNT_LAST;
               end else w_boundary = 1'b1;
            end else w_cnt_nxt = r_cnt - 1'b1;
         end
`ifdef UART_TX_BREAK_EN
         S_BREAK: begin
            w_out = 1'b0;
            if (r_brk_cnt != '0) w_brk_cnt_nxt = r_brk_cnt - 1'b1;
            else if (!i_break) begin
               w_state_nxt = S_MARK;
               w_cnt_nxt   = CNT_LAST;
            end
         end
         S_MARK: begin
            if (w_tick) w_boundary = 1'b1;
            else w_cnt_nxt = r_cnt - 1'b1;
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase

      // Frame boundary: break request wins over a pending pop; a pop goes straight to START.
      if (w_boundary) begin
         w_state_nxt = S_IDLE;
`ifdef UART_TX_BREAK_EN
         if (i_break) begin
            w_state_nxt   = S_BREAK;
            w_brk_cnt_nxt = BRK_BASE + (^i_parity_mode ? BRK_BIT : '0) + (i_two_stop ? BRK_BIT : '0);
         end else
`endif
         if (!w_empty) begin
            w_pop          = 1'b1;
            w_state_nxt    = S_START;
            w_cnt_nxt      = CNT_LAST;
            w_bit_idx_nxt  = '0;
            w_shift_nxt    = w_head;
            w_par_en_nxt   = ^i_parity_mode;
            w_par_bit_nxt  = (i_parity_mode == 2'b01) ? ~^w_head : ^w_head;
            w_two_stop_nxt = i_two_stop;
            w_stop_idx_nxt = 1'b0;
         end
      end
   end

   assign o_out        = ~i_rst_n | w_out;
   assign o_busy       = i_rst_n & (r_state != S_IDLE);
   assign o_ready      = ~i_rst_n | ~w_full;
   assign o_fifo_level = i_rst_n ? r_level : '0;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: scoreboard of queued characters compared bit-by-bit against o_out.
module tb_uart_tx_fifo;
   localparam int CPB = 10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] i_data;
   logic       i_valid;
   logic       o_ready;
   logic [1:0] i_parity_mode;
   logic       i_two_stop;
   logic       i_break;
   logic       o_out;
   logic       o_busy;
   logic [2:0] o_fifo_level;

   always #5 clk = ~clk;

   uart_tx_fifo #(
      .CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .FIFO_DEPTH(4)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
      .i_parity_mode(i_parity_mode), .i_two_stop(i_two_stop), .i_break(i_break),
      .o_out(o_out), .o_busy(o_busy), .o_fifo_level(o_fifo_level)
   );

   typedef struct {
      logic [7:0] data;
      logic [1:0] mode;
      logic       two;
   } frame_t;

   frame_t sb[$];
   int pass_cnt  = 0;
   int total_cnt = 0;

   function automatic void expect_char(input logic [7:0] d, input logic [1:0] m, input logic t);
      sb.push_back('{data: d, mode: m, two: t});
   endfunction

   task automatic push(input logic [7:0] d);
      i_data  = d;
      i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
   endtask

   // Waits (bounded) for a start bit, then compares every cycle of the frame against the scoreboard head.
   task automatic rx_frame(input int wait_max, output int busy_cnt);
      frame_t f;
      logic   exp_bits[13];
      int     nb, waited, bad_cyc;
      logic   bad_got, bad_exp;
      busy_cnt = 0;
      waited   = 0;
      while (o_out !== 1'b0 && waited < wait_max) begin
         @(negedge clk);
         waited++;
      end
      total_cnt++;
      if (o_out !== 1'b0) begin
         $display("FAIL start_bit: o_out=%b after %0d cycles, required 0", o_out, waited);
         return;
      end
      pass_cnt++;
      total_cnt++;
      if (sb.size() == 0) begin
         $display("FAIL scoreboard: frame seen with no queued expectation");
         return;
      end
      pass_cnt++;
      f  = sb.pop_front();
      nb = 0;
      exp_bits[nb] = 1'b0; nb++;
      for (int i = 0; i < 8; i++) begin
         exp_bits[nb] = f.data[i]; nb++;
      end
      if (f.mode == 2'b01) begin exp_bits[nb] = ~^f.data; nb++; end
      if (f.mode == 2'b10) begin exp_bits[nb] = ^f.data;  nb++; end
      exp_bits[nb] = 1'b1; nb++;
      if (f.two) begin exp_bits[nb] = 1'b1; nb++; end
      bad_cyc = -1;
      bad_got = 1'b0;
      bad_exp = 1'b0;
      for (int c = 0; c < nb * CPB; c++) begin
         if (o_out !== exp_bits[c / CPB] && bad_cyc < 0) begin
            bad_cyc = c;
            bad_got = o_out;
            bad_exp = exp_bits[c / CPB];
         end
         if (o_busy === 1'b1) busy_cnt++;
         @(negedge clk);
      end
      total_cnt++;
      if (bad_cyc >= 0)
         $display("FAIL frame data=%h mode=%b: cycle %0d o_out=%b, required %b", f.data, f.mode, bad_cyc, bad_got, bad_exp);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total_cnt++;
      if (o_out !== 1'b1 || o_busy !== 1'b0) $display("FAIL reset_held: o_out=%b o_busy=%b, required 1/0", o_out, o_busy);
      else pass_cnt++;
      rst_n = 1'b1;
      #1;
      total_cnt++;
      if (o_out !== 1'b1) $display("FAIL reset_out: o_out=%b, required 1", o_out); else pass_cnt++;
      total_cnt++;
      if (o_busy !== 1'b0) $display("FAIL reset_busy: o_busy=%b, required 0", o_busy); else pass_cnt++;
      total_cnt++;
      if (o_fifo_level !== 3'd0) $display("FAIL reset_level: level=%0d, required 0", o_fifo_level); else pass_cnt++;
      total_cnt++;
      if (o_ready !== 1'b1) $display("FAIL reset_ready: o_ready=%b, required 1", o_ready); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_8n1();
      int b;
      expect_char(8'h55, 2'b00, 1'b0);
      push(8'h55);
      total_cnt++;
      if (o_fifo_level !== 3'd1 || o_out !== 1'b1)
         $display("FAIL 8n1_t1: level=%0d o_out=%b, required 1/1", o_fifo_level, o_out);
      else pass_cnt++;
      @(negedge clk);
      rx_frame(0, b);
      total_cnt++;
      if (b !== 100) $display("FAIL 8n1_busy_len: busy cycles=%0d, required 100", b); else pass_cnt++;
      total_cnt++;
      if (o_busy !== 1'b0 || o_out !== 1'b1)
         $display("FAIL 8n1_idle_after: o_busy=%b o_out=%b, required 0/1", o_busy, o_out);
      else pass_cnt++;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_parity();
      int b;
      i_parity_mode = 2'b10;
      expect_char(8'h07, 2'b10, 1'b0);
      push(8'h07);
      @(negedge clk);
      rx_frame(0, b);
      total_cnt++;
      if (b !== 110) $display("FAIL even_busy_len: busy cycles=%0d, required 110", b); else pass_cnt++;
      i_parity_mode = 2'b01;
      expect_char(8'h07, 2'b01, 1'b0);
      push(8'h07);
      rx_frame(5, b);
      i_two_stop = 1'b1;
      expect_char(8'h07, 2'b01, 1'b1);
      push(8'h07);
      rx_frame(5, b);
      total_cnt++;
      if (b !== 120) $display("FAIL odd2_busy_len: busy cycles=%0d, required 120", b); else pass_cnt++;
      total_cnt++;
      if (o_busy !== 1'b0) $display("FAIL odd2_idle_after: o_busy=%b, required 0", o_busy); else pass_cnt++;
      i_parity_mode = 2'b00;
      i_two_stop    = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_fifo_full();
      int b0, b1;
      logic [7:0] chars[6];
      chars = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66};
      for (int k = 0; k < 5; k++) expect_char(chars[k], 2'b00, 1'b0);
      fork
         begin
            for (int k = 0; k < 6; k++) begin
               if (k == 5) begin
                  total_cnt++;
                  if (o_ready !== 1'b0 || o_fifo_level !== 3'd4)
                     $display("FAIL full_6th: o_ready=%b level=%0d, required 0/4", o_ready, o_fifo_level);
                  else pass_cnt++;
               end
               i_data  = chars[k];
               i_valid = 1'b1;
               @(negedge clk);
            end
            i_valid = 1'b0;
         end
         begin
            rx_frame(10, b0);
            for (int f = 0; f < 4; f++) rx_frame(0, b1);
         end
      join
      total_cnt++;
      if (o_busy !== 1'b0 || o_fifo_level !== 3'd0)
         $display("FAIL full_drained: o_busy=%b level=%0d, required 0/0", o_busy, o_fifo_level);
      else pass_cnt++;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int b, high_bad;
      expect_char(8'hC1, 2'b00, 1'b0);
      i_data = 8'hC1; i_valid = 1'b1; @(negedge clk);
      i_data = 8'hC2; @(negedge clk);
      i_data = 8'hC3; @(negedge clk);
      i_valid = 1'b0;
      total_cnt++;
      if (o_fifo_level !== 3'd2) $display("FAIL rstmid_queued: level=%0d, required 2", o_fifo_level); else pass_cnt++;
      repeat (42) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total_cnt++;
      if (o_out !== 1'b1 || o_busy !== 1'b0 || o_fifo_level !== 3'd0)
         $display("FAIL rstmid_after: o_out=%b o_busy=%b level=%0d, required 1/0/0", o_out, o_busy, o_fifo_level);
      else pass_cnt++;
      sb.delete();
      @(negedge clk);
      high_bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (o_out !== 1'b1 || o_busy !== 1'b0) high_bad++;
         @(negedge clk);
      end
      total_cnt++;
      if (high_bad != 0) $display("FAIL rstmid_quiet: %0d active cycles, required 0", high_bad); else pass_cnt++;
      expect_char(8'hA3, 2'b00, 1'b0);
      push(8'hA3);
      @(negedge clk);
      rx_frame(0, b);
      total_cnt++;
      if (b !== 100) $display("FAIL rstmid_busy_len: busy cycles=%0d, required 100", b); else pass_cnt++;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_cfg_mid();
      int b1, b2;
      expect_char(8'h3B, 2'b00, 1'b0);
      expect_char(8'h3B, 2'b10, 1'b0);
      i_data = 8'h3B; i_valid = 1'b1; @(negedge clk);
      @(negedge clk);
      i_valid = 1'b0;
      fork
         begin
            rx_frame(0, b1);
            rx_frame(0, b2);
         end
         begin
            repeat (35) @(negedge clk);
            i_parity_mode = 2'b10;
         end
      join
      total_cnt++;
      if (b1 !== 100 || b2 !== 110)
         $display("FAIL cfg_mid_len: lengths=%0d,%0d, required 100,110", b1, b2);
      else pass_cnt++;
      i_parity_mode = 2'b00;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_break();
      int b;
      expect_char(8'h3C, 2'b00, 1'b0);
      i_data = 8'h3C; i_valid = 1'b1; i_break = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
`ifdef UART_TX_BREAK_EN
      begin
         int low_bad, high_bad;
         logic [2:0] lvl_mid;
         logic busy_mid;
         low_bad = 0; high_bad = 0; lvl_mid = '0; busy_mid = 1'b0;
         for (int i = 1; i <= 150; i++) begin
            if (o_out !== 1'b0) low_bad++;
            if (i == 75) begin lvl_mid = o_fifo_level; busy_mid = o_busy; end
            if (i < 150) @(negedge clk);
         end
         i_break = 1'b0;
         @(negedge clk);
         for (int i = 0; i < 10; i++) begin
            if (o_out !== 1'b1) high_bad++;
            @(negedge clk);
         end
         total_cnt++;
         if (low_bad != 0) $display("FAIL break_low: %0d high cycles in break, required 0", low_bad); else pass_cnt++;
         total_cnt++;
         if (lvl_mid !== 3'd1 || busy_mid !== 1'b1)
            $display("FAIL break_mid: level=%0d busy=%b, required 1/1", lvl_mid, busy_mid);
         else pass_cnt++;
         total_cnt++;
         if (high_bad != 0) $display("FAIL break_mark: %0d low cycles in mark, required 0", high_bad); else pass_cnt++;
         rx_frame(0, b);
      end
`else
      @(negedge clk);
      rx_frame(0, b);
      i_break = 1'b0;
`endif
      total_cnt++;
      if (b !== 100) $display("FAIL break_frame_len: busy cycles=%0d, required 100", b); else pass_cnt++;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      i_data        = '0;
      i_valid       = 1'b0;
      i_parity_mode = 2'b00;
      i_two_stop    = 1'b0;
      i_break       = 1'b0;
      @(negedge clk);
      test_reset();
      test_8n1();
      test_parity();
      test_fifo_full();
      test_reset_mid();
      test_cfg_mid();
      test_break();
      total_cnt++;
      if (sb.size() != 0) $display("FAIL scoreboard_leftover: %0d entries, required 0", sb.size()); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
